// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the raw lines, frames bytes,
// and turns make/break scancodes into level-held game key signals.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_left,
    output logic       key_right,
    output logic       key_down,
    output logic       key_rotate,
    output logic       key_drop,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       scan_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                state;
    state_t                next_state;
    logic                  clk_s1;
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  data_s1;
    logic                  data_s2;
    logic                  fclk;
    logic                  fall;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;
    logic                  par_bit;
    logic [TW-1:0]         tcnt;
    logic                  timeout;
    logic                  frame_done;
    logic                  frame_good;
    logic                  frame_err;
    logic                  ext;
    logic                  brk;

    // clk_hist[0] doubles as the second synchronizer stage for ps2_clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_hist <= '1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_s1};
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fclk <= 1'b1;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (fclk && (clk_hist == '0)) begin
                fclk <= 1'b0;
                fall <= 1'b1;
            end else if (!fclk && (&clk_hist)) begin
                fclk <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fall && !data_s2) next_state = DATA;
            DATA:    if (fall && bit_cnt == 3'd7) next_state = PARITY;
            PARITY:  if (fall) next_state = STOP;
            STOP:    if (fall) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (timeout) next_state = IDLE;
    end

    always_comb begin
        timeout    = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES));
        frame_done = (state == STOP) && fall;
        frame_good = frame_done && data_s2 && (^{shift, par_bit});
        frame_err  = (frame_done && !frame_good) || timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            par_bit <= 1'b0;
            tcnt    <= '0;
        end else begin
            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= 3'd0;
                    DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= data_s2;
                    default: ;
                endcase
            end
            if (state == IDLE || fall) tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
        end
    end

    // Prefix flags and key levels update together with the scan_valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_valid <= 1'b0;
            scan_err   <= 1'b0;
            scan_code  <= 8'h00;
            ext        <= 1'b0;
            brk        <= 1'b0;
            key_left   <= 1'b0;
            key_right  <= 1'b0;
            key_down   <= 1'b0;
            key_rotate <= 1'b0;
            key_drop   <= 1'b0;
        end else begin
            scan_valid <= frame_good;
            scan_err   <= frame_err;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (frame_good) begin
                scan_code <= shift;
                case (shift)
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    default: begin
                        if (ext) begin
                            case (shift)
                                8'h6B:   key_left   <= !brk;
                                8'h74:   key_right  <= !brk;
                                8'h72:   key_down   <= !brk;
                                8'h75:   key_rotate <= !brk;
                                default: ;
                            endcase
                        end else if (shift == 8'h29) begin
                            key_drop <= !brk;
                        end
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: PS/2 frames are bit-banged on the raw lines and a
// queue-based model of expected bytes/errors plus key levels is compared every cycle.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 3000;
    localparam int HALF       = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_left, key_right, key_down, key_rotate, key_drop;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       scan_err;

    ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_left(key_left), .key_right(key_right), .key_down(key_down),
        .key_rotate(key_rotate), .key_drop(key_drop),
        .scan_valid(scan_valid), .scan_code(scan_code), .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] code;
    } ev_t;

    ev_t        exp_q[$];
    logic [4:0] m_keys;
    logic [7:0] m_code;
    bit         m_ext, m_brk;
    bit         chk_en;
    int         checks = 0;
    int         errors = 0;
    int         n_valid = 0;
    int         n_err = 0;
    // {extended, code} per key; entry i drives bit 4-i of {left,right,down,rotate,drop}
    logic [8:0] key_tab [5] = '{9'h16B, 9'h174, 9'h172, 9'h175, 9'h029};

    wire [4:0] keys = {key_left, key_right, key_down, key_rotate, key_drop};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            for (int i = 0; i < 5; i++)
                if (key_tab[i] == {m_ext, b}) m_keys[4-i] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_err_exclusive", {31'd0, scan_valid & scan_err}, 32'd0);
            if (scan_valid) n_valid++;
            if (scan_err) n_err++;
            if (scan_valid || scan_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, scan_valid, scan_err}, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_kind", {31'd0, scan_err}, {31'd0, e.err});
                    if (e.err) begin
                        m_ext = 1'b0;
                        m_brk = 1'b0;
                    end else begin
                        model_byte(e.code);
                    end
                end
            end
            check("keys", {27'd0, keys}, {27'd0, m_keys});
            check("scan_code", {24'd0, scan_code}, {24'd0, m_code});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            cycles(15);
            ps2_clk = 1'b0;
            cycles(3);
            ps2_clk = 1'b1;
            cycles(HALF - 18);
        end else begin
            cycles(HALF);
        end
        ps2_clk = 1'b0;
        cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        ev_t e;
        e.err  = bad_par;
        e.code = b;
        exp_q.push_back(e);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit((~^b) ^ bad_par, glitch);
        send_bit(1'b1, glitch);
        ps2_data = 1'b1;
        cycles(100);
    endtask

    task automatic send_partial(input logic [7:0] b);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst    = 1'b1;
        cycles(3);
        rst    = 1'b0;
        exp_q.delete();
        m_keys = 5'b0;
        m_code = 8'h00;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        @(negedge clk);
        check("rst_keys", {27'd0, keys}, 32'd0);
        check("rst_code", {24'd0, scan_code}, 32'd0);
        check("rst_valid", {31'd0, scan_valid}, 32'd0);
        check("rst_err", {31'd0, scan_err}, 32'd0);
        chk_en = 1'b1;
        cycles(5);
    endtask

    initial begin
        int v0, e0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        chk_en   = 1'b0;
        rst      = 1'b1;
        cycles(5);
        do_reset();

        v0 = n_valid;
        send_frame(8'h29, 0, 0);
        check("t1_valid_count", n_valid - v0, 1);
        check("t1_code", {24'd0, scan_code}, 32'h29);
        check("t1_drop_make", {31'd0, key_drop}, 1);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h29, 0, 0);
        check("t1_drop_break", {31'd0, key_drop}, 0);
        check("t1_valid_count3", n_valid - v0, 3);

        send_frame(8'hE0, 0, 0);
        send_frame(8'h6B, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h74, 0, 0);
        check("t2_left_right", {27'd0, keys}, 32'h18);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h6B, 0, 0);
        check("t2_left_released", {27'd0, keys}, 32'h08);

        v0 = n_valid;
        send_frame(8'h6B, 0, 0);
        check("t3_valid", n_valid - v0, 1);
        check("t3_code", {24'd0, scan_code}, 32'h6B);
        check("t3_keys_same", {27'd0, keys}, 32'h08);

        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h75, 1, 0);
        check("t4_err_count", n_err - e0, 1);
        check("t4_no_valid", n_valid - v0, 0);
        check("t4_rotate_low", {31'd0, key_rotate}, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        check("t4_rotate_high", {31'd0, key_rotate}, 1);

        e0 = n_err;
        begin
            ev_t e;
            e.err  = 1'b1;
            e.code = 8'h00;
            send_partial(8'h55);
            exp_q.push_back(e);
        end
        cycles(TIMEOUT + 10);
        check("t5_timeout_err", n_err - e0, 1);
        check("t5_queue_empty", exp_q.size(), 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h72, 0, 0);
        check("t5_down", {31'd0, key_down}, 1);

        send_frame(8'h29, 0, 1);
        check("t6_glitch_code", {24'd0, scan_code}, 32'h29);
        check("t6_glitch_drop", {31'd0, key_drop}, 1);
        check("t6_keys", {27'd0, keys}, 32'h0F);

        send_partial(8'hE0);
        do_reset();
        send_frame(8'h29, 0, 0);
        check("t7_after_reset", {27'd0, keys}, 32'h01);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
